id_ex_pipe_reg: RTL

ID/EX pipeline register of the segmented ARMv8 core. Captures decode-stage control (after the stall mux has zeroed it on a hazard), operands, immediate and register indices on each clock edge and presents them to the execute stage. Supports a freeze request (Hold) from the hazard unit and a flush (Flush) from branch resolution, and tracks a valid bit so downstream stages and the hazard unit can tell real instructions from bubbles.

---
 rtl/id_ex_pipe_reg.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg
// Brief    : ID/EX pipeline register of the segmented ARMv8 core. Registers
//            decode control, operands, immediate and register indices for the
//            execute stage, with freeze (Hold), squash (Flush) and a valid bit.
//            Optional bubble statistics counter enabled by the macro
//            ID_EX_BUBBLE_CNT_EN; without it BubbleCount is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
  parameter int DATA_W  = 64,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2,
  parameter int OPC_W   = 11
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               Hold,
  input  logic               Flush,
  input  logic               Branch,
  input  logic               RegWrite,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               MemtoReg,
  input  logic               ALUSrc,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [DATA_W-1:0]  PCIn,
  input  logic [DATA_W-1:0]  ReadData1,
  input  logic [DATA_W-1:0]  ReadData2,
  input  logic [DATA_W-1:0]  SignExtImm,
  input  logic [OPC_W-1:0]   Opcode,
  input  logic [REG_W-1:0]   Rn,
  input  logic [REG_W-1:0]   Rm,
  input  logic [REG_W-1:0]   Rd,
  input  logic               ValidIn,
  output logic               ExBranch,
  output logic               ExRegWrite,
  output logic               ExMemRead,
  output logic               ExMemWrite,
  output logic               ExMemtoReg,
  output logic               ExALUSrc,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic [DATA_W-1:0]  ExPC,
  output logic [DATA_W-1:0]  ExReadData1,
  output logic [DATA_W-1:0]  ExReadData2,
  output logic [DATA_W-1:0]  ExImm,
  output logic [OPC_W-1:0]   ExOpcode,
  output logic [REG_W-1:0]   ExRn,
  output logic [REG_W-1:0]   ExRm,
  output logic [REG_W-1:0]   ExRd,
  output logic               ExValid,
  output logic [31:0]        BubbleCount
);

  // Control fields are squashed by Flush; data fields only ever load or hold.
  logic               branch_q,   branch_d;
  logic               regwrite_q, regwrite_d;
  logic               memread_q,  memread_d;
  logic               memwrite_q, memwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic               alusrc_q,   alusrc_d;
  logic [ALUOP_W-1:0] aluop_q,    aluop_d;
  logic               valid_q,    valid_d;

  logic [DATA_W-1:0]  pc_q,  pc_d;
  logic [DATA_W-1:0]  rd1_q, rd1_d;
  logic [DATA_W-1:0]  rd2_q, rd2_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [REG_W-1:0]   rn_q,  rn_d;
  logic [REG_W-1:0]   rm_q,  rm_d;
  logic [REG_W-1:0]   rdx_q, rdx_d;

  // Next-state selection: Flush beats Hold beats load; default is retain.
  always_comb begin
    branch_d   = branch_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    opc_d      = opc_q;
    rn_d       = rn_q;
    rm_d       = rm_q;
    rdx_d      = rdx_q;

    if (Flush) begin
      branch_d   = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      alusrc_d   = 1'b0;
      aluop_d    = '0;
      valid_d    = 1'b0;
    end else if (!Hold) begin
      branch_d   = Branch;
      regwrite_d = RegWrite;
      memread_d  = MemRead;
      memwrite_d = MemWrite;
      memtoreg_d = MemtoReg;
      alusrc_d   = ALUSrc;
      aluop_d    = ALUOp;
      valid_d    = ValidIn;
      pc_d       = PCIn;
      rd1_d      = ReadData1;
      rd2_d      = ReadData2;
      imm_d      = SignExtImm;
      opc_d      = Opcode;
      rn_d       = Rn;
      rm_d       = Rm;
      rdx_d      = Rd;
    end
  end

  // Pipeline state register with asynchronous clear.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      branch_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      opc_q      <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      rdx_q      <= '0;
    end else begin
      branch_q   <= branch_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      opc_q      <= opc_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      rdx_q      <= rdx_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_w;

  // A bubble enters EX on a flush, or on a non-held load of an invalid slot.
  always_comb begin
    bubble_w     = Flush | (!Hold & !ValidIn);
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_w && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Saturating bubble counter, cleared only by reset.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign BubbleCount = bubble_cnt_q;
`else
  assign BubbleCount = 32'h0;
`endif

  assign ExBranch    = branch_q;
  assign ExRegWrite  = regwrite_q;
  assign ExMemRead   = memread_q;
  assign ExMemWrite  = memwrite_q;
  assign ExMemtoReg  = memtoreg_q;
  assign ExALUSrc    = alusrc_q;
  assign ExALUOp     = aluop_q;
  assign ExValid     = valid_q;
  assign ExPC        = pc_q;
  assign ExReadData1 = rd1_q;
  assign ExReadData2 = rd2_q;
  assign ExImm       = imm_q;
  assign ExOpcode    = opc_q;
  assign ExRn        = rn_q;
  assign ExRm        = rm_q;
  assign ExRd        = rdx_q;

endmodule
`default_nettype wire
